alu_station: RTL and testbench

- Receiving end of the allocator→ALU dispatch interface: a single-slot ALU reservation station plus a one-deep result buffer.
- Captures a dispatched op with operands or tags, and snoops the common data bus (CDB) until both operands resolve.
- Executes the 4-bit ALU op, then requests the CDB to broadcast the result under its write tag.
- Reports busy and pending tags back to the allocator, which uses them to decide whether it may dispatch again.

---
 rtl/alu_station.sv | 206 ++++++++++++++++++++
 tb/tb_alu_station.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_station.sv
// Single-slot ALU reservation station with a one-deep result buffer.
// Optional protocol checker: define ALU_STATION_CHECK_EN to add proto_err.
module alu_station #(
  parameter int TAG_W  = 4,
  parameter int ADDR_W = 5,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              en_in,
  input  logic [3:0]        op_in,
  input  logic [TAG_W-1:0]  tagx_in,
  input  logic [TAG_W-1:0]  tagy_in,
  input  logic [TAG_W-1:0]  tagw_in,
  input  logic [WORD_W-1:0] datax_in,
  input  logic [WORD_W-1:0] datay_in,
  input  logic [ADDR_W-1:0] addrw_in,
  output logic              busy,
  output logic [TAG_W-1:0]  tagx_out,
  output logic [TAG_W-1:0]  tagy_out,
  output logic [TAG_W-1:0]  tagw_out,
  input  logic              cdb_en,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [WORD_W-1:0] cdb_data,
  output logic              res_req,
  output logic [TAG_W-1:0]  res_tag,
  output logic [WORD_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_addr,
  input  logic              res_grant
`ifdef ALU_STATION_CHECK_EN
  ,
  output logic              proto_err
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_READY
  } slot_e;

  slot_e             state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [TAG_W-1:0]  tagx_q, tagx_d;
  logic [TAG_W-1:0]  tagy_q, tagy_d;
  logic [TAG_W-1:0]  tagw_q, tagw_d;
  logic [WORD_W-1:0] x_q, x_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] addrw_q, addrw_d;

  logic              rreq_q, rreq_d;
  logic [TAG_W-1:0]  rtag_q, rtag_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;

  logic              issue;
  logic              accept;
  logic              fx_hit, fy_hit;
  logic [TAG_W-1:0]  ntagx, ntagy;
  logic [WORD_W-1:0] nx, ny;

  function automatic logic [WORD_W-1:0] alu_f(
    input logic [3:0]        op,
    input logic [WORD_W-1:0] a,
    input logic [WORD_W-1:0] b
  );
    logic [4:0] sh;
    logic [WORD_W-1:0] r;
    sh = b[4:0];
    r  = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << sh;
      4'd3: r = {{(WORD_W-1){1'b0}}, $signed(a) < $signed(b)};
      4'd4: r = {{(WORD_W-1){1'b0}}, a < b};
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: r = WORD_W'($signed(a) >>> sh);
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Dispatch operands after same-cycle CDB forwarding.
  always_comb begin
    fx_hit = (tagx_in != '0) && cdb_en && (cdb_tag == tagx_in);
    fy_hit = (tagy_in != '0) && cdb_en && (cdb_tag == tagy_in);
    ntagx  = fx_hit ? '0 : tagx_in;
    ntagy  = fy_hit ? '0 : tagy_in;
    nx     = fx_hit ? cdb_data : datax_in;
    ny     = fy_hit ? cdb_data : datay_in;
  end

  // Slot and result-buffer next state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tagx_d  = tagx_q;
    tagy_d  = tagy_q;
    tagw_d  = tagw_q;
    x_d     = x_q;
    y_d     = y_q;
    addrw_d = addrw_q;
    rreq_d  = rreq_q;
    rtag_d  = rtag_q;
    rdata_d = rdata_q;
    raddr_d = raddr_q;

    issue  = (state_q == S_READY) && (!rreq_q || res_grant);
    accept = en_in && ((state_q == S_EMPTY) || issue);

    if (state_q == S_WAIT) begin
      if (tagx_q != '0 && cdb_en && cdb_tag == tagx_q) begin
        tagx_d = '0;
        x_d    = cdb_data;
      end
      if (tagy_q != '0 && cdb_en && cdb_tag == tagy_q) begin
        tagy_d = '0;
        y_d    = cdb_data;
      end
      if (tagx_d == '0 && tagy_d == '0) state_d = S_READY;
    end

    if (issue) state_d = S_EMPTY;

    if (accept) begin
      op_d    = op_in;
      tagx_d  = ntagx;
      tagy_d  = ntagy;
      tagw_d  = tagw_in;
      x_d     = nx;
      y_d     = ny;
      addrw_d = addrw_in;
      state_d = (ntagx == '0 && ntagy == '0) ? S_READY : S_WAIT;
    end

    if (issue) begin
      rreq_d  = 1'b1;
      rtag_d  = tagw_q;
      rdata_d = alu_f(op_q, x_q, y_q);
      raddr_d = addrw_q;
    end else if (rreq_q && res_grant) begin
      rreq_d  = 1'b0;
    end
  end

  // State registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      op_q    <= '0;
      tagx_q  <= '0;
      tagy_q  <= '0;
      tagw_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addrw_q <= '0;
      rreq_q  <= 1'b0;
      rtag_q  <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      op_q    <= op_d;
      tagx_q  <= tagx_d;
      tagy_q  <= tagy_d;
      tagw_q  <= tagw_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addrw_q <= addrw_d;
      rreq_q  <= rreq_d;
      rtag_q  <= rtag_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
    end
  end

`ifdef ALU_STATION_CHECK_EN
  logic perr_q;

  // Sticky flag for dropped or untagged dispatches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= 1'b0;
    end else if (rdy && en_in && (!accept || tagw_in == '0)) begin
      perr_q <= 1'b1;
    end
  end

  assign proto_err = perr_q;
`endif

  assign busy     = (state_q != S_EMPTY) || rreq_q;
  assign tagx_out = (state_q != S_EMPTY) ? tagx_q : '0;
  assign tagy_out = (state_q != S_EMPTY) ? tagy_q : '0;
  assign tagw_out = (state_q == S_WAIT) ? tagw_q : '0;
  assign res_req  = rreq_q;
  assign res_tag  = rtag_q;
  assign res_data = rdata_q;
  assign res_addr = raddr_q;

endmodule

// File: tb/tb_alu_station.sv
// Directed self-checking bench for alu_station.
// Covers dispatch, snoop, forwarding, back-pressure, drop, freeze, reset.
module tb_alu_station;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        en_in;
  logic [3:0]  op_in;
  logic [3:0]  tagx_in, tagy_in, tagw_in;
  logic [31:0] datax_in, datay_in;
  logic [4:0]  addrw_in;
  logic        busy;
  logic [3:0]  tagx_out, tagy_out, tagw_out;
  logic        cdb_en;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        res_req;
  logic [3:0]  res_tag;
  logic [31:0] res_data;
  logic [4:0]  res_addr;
  logic        res_grant;
`ifdef ALU_STATION_CHECK_EN
  logic        proto_err;
`endif

  int errors = 0;
  int checks = 0;

  alu_station dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .en_in(en_in), .op_in(op_in),
    .tagx_in(tagx_in), .tagy_in(tagy_in),
    .tagw_in(tagw_in),
    .datax_in(datax_in), .datay_in(datay_in),
    .addrw_in(addrw_in), .busy(busy),
    .tagx_out(tagx_out), .tagy_out(tagy_out),
    .tagw_out(tagw_out),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .res_req(res_req), .res_tag(res_tag),
    .res_data(res_data), .res_addr(res_addr),
    .res_grant(res_grant)
`ifdef ALU_STATION_CHECK_EN
    , .proto_err(proto_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_in = 0; op_in = 0;
    tagx_in = 0; tagy_in = 0; tagw_in = 0;
    datax_in = 0; datay_in = 0; addrw_in = 0;
    cdb_en = 0; cdb_tag = 0; cdb_data = 0;
    res_grant = 0;
  endtask

  task automatic disp(input logic [3:0] op,
                      input logic [3:0] tx, input logic [31:0] x,
                      input logic [3:0] ty, input logic [31:0] y,
                      input logic [3:0] tw, input logic [4:0] aw);
    en_in = 1; op_in = op;
    tagx_in = tx; datax_in = x;
    tagy_in = ty; datay_in = y;
    tagw_in = tw; addrw_in = aw;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%0b exp=0", busy);
    end
    checks++;
    if (res_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got=%0b exp=0", res_req);
    end
    checks++;
    if ({tagx_out, tagy_out, tagw_out} !== 12'h0) begin
      errors++;
      $display("FAIL reset_tags got=%h exp=0", {tagx_out, tagy_out, tagw_out});
    end
    checks++;
    if ({res_tag, res_data, res_addr} !== 41'h0) begin
      errors++;
      $display("FAIL reset_res got=%h exp=0", {res_tag, res_data, res_addr});
    end
  endtask

  task automatic test_ready_operands();
    disp(4'd0, 0, 32'd5, 0, 32'd7, 4'd3, 5'd9);
    tick();
    en_in = 0;
    checks++;
    if (busy !== 1'b1 || res_req !== 1'b0) begin
      errors++; $display("FAIL rdy_slot busy=%0b req=%0b exp 1/0", busy, res_req);
    end
    tick();
    checks++;
    if (res_req !== 1'b1 || res_data !== 32'd12 || res_tag !== 4'd3
        || res_addr !== 5'd9) begin
      errors++;
      $display("FAIL rdy_result req=%0b data=%0d tag=%0d addr=%0d exp 1/12/3/9",
               res_req, res_data, res_tag, res_addr);
    end
    res_grant = 1;
    tick();
    res_grant = 0;
    checks++;
    if (busy !== 1'b0 || res_req !== 1'b0) begin
      errors++; $display("FAIL rdy_done busy=%0b req=%0b exp 0/0", busy, res_req);
    end
  endtask

  task automatic test_tag_wait();
    disp(4'd1, 4'd2, 32'hDEAD, 0, 32'd10, 4'd5, 5'd1);
    tick();
    en_in = 0;
    checks++;
    if (tagx_out !== 4'd2 || tagw_out !== 4'd5 || res_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_tags tx=%0d tw=%0d req=%0b exp 2/5/0",
               tagx_out, tagw_out, res_req);
    end
    cdb_en = 1; cdb_tag = 4'd9; cdb_data = 32'd77;
    tick();
    checks++;
    if (tagx_out !== 4'd2 || res_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_nomatch tx=%0d req=%0b exp 2/0", tagx_out, res_req);
    end
    cdb_tag = 4'd2; cdb_data = 32'd25;
    tick();
    cdb_en = 0;
    checks++;
    if (tagx_out !== 4'd0 || tagw_out !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_snoop tx=%0d tw=%0d busy=%0b exp 0/0/1",
               tagx_out, tagw_out, busy);
    end
    tick();
    checks++;
    if (res_req !== 1'b1 || res_data !== 32'd15 || res_tag !== 4'd5) begin
      errors++;
      $display("FAIL wait_result req=%0b data=%0d tag=%0d exp 1/15/5",
               res_req, res_data, res_tag);
    end
    res_grant = 1;
    tick();
    res_grant = 0;
  endtask

  task automatic test_forward();
    disp(4'd3, 0, 32'd1, 4'd4, 32'd0, 4'd6, 5'd2);
    cdb_en = 1; cdb_tag = 4'd4; cdb_data = 32'h8000_0000;
    tick();
    en_in = 0; cdb_en = 0;
    checks++;
    if (tagy_out !== 4'd0 || tagw_out !== 4'd0) begin
      errors++;
      $display("FAIL fwd_tags ty=%0d tw=%0d exp 0/0", tagy_out, tagw_out);
    end
    tick();
    checks++;
    if (res_req !== 1'b1 || res_data !== 32'd0 || res_tag !== 4'd6) begin
      errors++;
      $display("FAIL fwd_result req=%0b data=%h tag=%0d exp 1/0/6",
               res_req, res_data, res_tag);
    end
    res_grant = 1;
    tick();
    res_grant = 0;
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [11];
    logic [31:0] xs  [11];
    logic [31:0] ys  [11];
    logic [31:0] es  [11];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9, 4'd12};
    xs  = '{32'hFFFF_FFFF, 32'd3, 32'd1, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'h0000_F0F0, 32'h8000_0000,
            32'h8000_0000, 32'h0F, 32'hFF, 32'd123};
    ys  = '{32'd1, 32'd5, 32'd33, 32'd1, 32'd1, 32'h0000_0FF0,
            32'd4, 32'd4, 32'hF0, 32'h3C, 32'd45};
    es  = '{32'd0, 32'hFFFF_FFFE, 32'd2, 32'd1, 32'd0,
            32'h0000_FF00, 32'h0800_0000, 32'hF800_0000,
            32'hFF, 32'h3C, 32'd0};
    for (int i = 0; i < 11; i++) begin
      disp(ops[i], 0, xs[i], 0, ys[i], 4'd7, 5'd3);
      tick();
      en_in = 0;
      tick();
      checks++;
      if (res_req !== 1'b1 || res_data !== es[i]) begin
        errors++;
        $display("FAIL alu_op%0d req=%0b data=%h exp 1/%h",
                 ops[i], res_req, res_data, es[i]);
      end
      res_grant = 1;
      tick();
      res_grant = 0;
    end
  endtask

  task automatic test_back_to_back();
    disp(4'd0, 0, 32'd1, 0, 32'd2, 4'd1, 5'd4);
    tick();
    en_in = 0;
    tick();
    disp(4'd0, 0, 32'd10, 0, 32'd20, 4'd2, 5'd5);
    tick();
    en_in = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res_req !== 1'b1 || res_data !== 32'd3 || res_tag !== 4'd1
          || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_hold%0d req=%0b data=%0d tag=%0d exp 1/3/1",
                 i, res_req, res_data, res_tag);
      end
      tick();
    end
    res_grant = 1;
    tick();
    res_grant = 0;
    checks++;
    if (res_req !== 1'b1 || res_data !== 32'd30 || res_tag !== 4'd2
        || res_addr !== 5'd5) begin
      errors++;
      $display("FAIL b2b_reload req=%0b data=%0d tag=%0d addr=%0d exp 1/30/2/5",
               res_req, res_data, res_tag, res_addr);
    end
    res_grant = 1;
    tick();
    res_grant = 0;
    checks++;
    if (res_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done req=%0b busy=%0b exp 0/0", res_req, busy);
    end
  endtask

  task automatic test_drop();
    disp(4'd0, 4'd7, 32'd0, 0, 32'd100, 4'd8, 5'd6);
    tick();
    disp(4'd1, 0, 32'd50, 0, 32'd1, 4'd9, 5'd7);
    tick();
    en_in = 0;
    checks++;
    if (tagx_out !== 4'd7 || tagw_out !== 4'd8) begin
      errors++;
      $display("FAIL drop_keep tx=%0d tw=%0d exp 7/8", tagx_out, tagw_out);
    end
`ifdef ALU_STATION_CHECK_EN
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL drop_err got=%0b exp=1", proto_err);
    end
`endif
    cdb_en = 1; cdb_tag = 4'd7; cdb_data = 32'd11;
    tick();
    cdb_en = 0;
    tick();
    checks++;
    if (res_req !== 1'b1 || res_data !== 32'd111 || res_tag !== 4'd8
        || res_addr !== 5'd6) begin
      errors++;
      $display("FAIL drop_result req=%0b data=%0d tag=%0d addr=%0d exp 1/111/8/6",
               res_req, res_data, res_tag, res_addr);
    end
    res_grant = 1;
    tick();
    res_grant = 0;
  endtask

  task automatic test_freeze_reset();
    disp(4'd0, 4'd3, 32'd0, 0, 32'd1, 4'd4, 5'd8);
    tick();
    en_in = 0;
    rdy = 0;
    cdb_en = 1; cdb_tag = 4'd3; cdb_data = 32'd40;
    tick();
    rdy = 1; cdb_en = 0;
    checks++;
    if (tagx_out !== 4'd3 || tagw_out !== 4'd4 || res_req !== 1'b0) begin
      errors++;
      $display("FAIL freeze_snoop tx=%0d tw=%0d req=%0b exp 3/4/0",
               tagx_out, tagw_out, res_req);
    end
    tick();
    checks++;
    if (tagx_out !== 4'd3 || res_req !== 1'b0) begin
      errors++;
      $display("FAIL freeze_after tx=%0d req=%0b exp 3/0", tagx_out, res_req);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || {tagx_out, tagy_out, tagw_out} !== 12'h0
        || res_req !== 1'b0) begin
      errors++;
      $display("FAIL async_rst busy=%0b tags=%h req=%0b exp 0/0/0",
               busy, {tagx_out, tagy_out, tagw_out}, res_req);
    end
`ifdef ALU_STATION_CHECK_EN
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL rst_err got=%0b exp=0", proto_err);
    end
`endif
    tick();
    rst = 1;
    tick();
  endtask

  initial begin
    idle();
    rdy = 1;
    rst = 1;
    #2 rst = 0;
    #20;
    test_reset();
    @(negedge clk);
    rst = 1;
    tick();
    test_ready_operands();
    test_tag_wait();
    test_forward();
    test_alu_ops();
    test_back_to_back();
    test_drop();
    test_freeze_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
